// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-atomic arbiter sharing one UART tx byte port among NREQ requesters
// Build option: UART_TX_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module uart_tx_arbiter #(
  parameter int NREQ = 3,
  parameter int GAP  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ack,
  input  logic              tx_rdy,
  output logic              tx_en,
  output logic [7:0]        tx_data,
  output logic [NREQ-1:0]   grant,
  output logic              busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   win;
  logic [3:0]      gap_cnt;
  logic            fire;
  logic [7:0]      lane;

`ifdef UART_TX_ARB_FIXED_PRIO_EN
  always_comb begin
    win = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[k]) win = IW'(k);
    end
  end
`else
  logic [IW-1:0] rr_ptr;

  // Scanning the rotated order backwards leaves the first hit from rr_ptr in win.
  always_comb begin
    int idx;
    idx = 0;
    win = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx]) win = IW'(idx);
    end
  end
`endif

  assign lane = req_data[8*owner +: 8];
  assign fire = (state == S_SEND) && tx_rdy && req[owner];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (|req) state_nxt = S_SEND;
      S_SEND: if ((fire && req_last[owner]) || !req[owner]) state_nxt = S_GAP;
      S_GAP:  if (gap_cnt == 4'd0) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant   <= '0;
      owner   <= '0;
      gap_cnt <= '0;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
      rr_ptr  <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (|req) begin
            grant <= {{(NREQ-1){1'b0}}, 1'b1} << win;
            owner <= win;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
            rr_ptr <= (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
`endif
          end
        end
        S_SEND: begin
          if ((fire && req_last[owner]) || !req[owner]) begin
            grant   <= '0;
            gap_cnt <= 4'(GAP - 1);
          end
        end
        S_GAP: begin
          if (gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;
        end
        default: grant <= '0;
      endcase
    end
  end

  // Everything facing the UART is gated by SEND so it is 0 whenever grant is 0.
  always_comb begin
    tx_en   = fire;
    req_ack = fire ? grant : '0;
    tx_data = (state == S_SEND) ? lane : 8'h00;
    busy    = (state != S_IDLE);
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter (NREQ=3, GAP=2)
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  req;
  logic [23:0] req_data;
  logic [2:0]  req_last;
  logic [2:0]  req_ack;
  logic        tx_rdy;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic [2:0]  grant;
  logic        busy;

  int n_chk;
  int n_fail;

  uart_tx_arbiter #(.NREQ(3), .GAP(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .req_last (req_last),
    .req_ack  (req_ack),
    .tx_rdy   (tx_rdy),
    .tx_en    (tx_en),
    .tx_data  (tx_data),
    .grant    (grant),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  req;
    logic [23:0] data;
    logic [2:0]  last;
    logic        rdy;
    logic        en;
    logic [7:0]  txd;
    logic [2:0]  ack;
    logic [2:0]  gnt;
    logic        bsy;
  } vec_t;

  vec_t tbl [24];

  function automatic vec_t mk(logic [2:0] r, logic [23:0] d, logic [2:0] l, logic y,
                              logic e, logic [7:0] t, logic [2:0] a, logic [2:0] g, logic b);
    vec_t v;
    v.req = r; v.data = d; v.last = l; v.rdy = y;
    v.en = e; v.txd = t; v.ack = a; v.gnt = g; v.bsy = b;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic e, input logic [7:0] t,
                         input logic [2:0] a, input logic [2:0] g, input logic b);
    check({nm, ".tx_en"},   32'(tx_en),   32'(e));
    check({nm, ".tx_data"}, 32'(tx_data), 32'(t));
    check({nm, ".req_ack"}, 32'(req_ack), 32'(a));
    check({nm, ".grant"},   32'(grant),   32'(g));
    check({nm, ".busy"},    32'(busy),    32'(b));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bi [2];
    int order [$];
    int exp_order [4];
    int cur;
    int who;

    n_chk = 0;
    n_fail = 0;
    rst = 1'b1; req = '0; req_data = '0; req_last = '0; tx_rdy = 1'b0;

    // packet 1 (31,32,0a), tx_rdy stalls, abort with waiting requester, single-byte packet
    tbl[0]  = mk(3'b001, 24'h000031, 3'b000, 1, 0, 8'h00, 3'b000, 3'b000, 0);
    tbl[1]  = mk(3'b001, 24'h000031, 3'b000, 1, 1, 8'h31, 3'b001, 3'b001, 1);
    tbl[2]  = mk(3'b001, 24'h000032, 3'b000, 1, 1, 8'h32, 3'b001, 3'b001, 1);
    tbl[3]  = mk(3'b001, 24'h00000a, 3'b001, 1, 1, 8'h0a, 3'b001, 3'b001, 1);
    tbl[4]  = mk(3'b000, 24'h000000, 3'b000, 1, 0, 8'h00, 3'b000, 3'b000, 1);
    tbl[5]  = mk(3'b000, 24'h000000, 3'b000, 1, 0, 8'h00, 3'b000, 3'b000, 1);
    tbl[6]  = mk(3'b000, 24'h000000, 3'b000, 1, 0, 8'h00, 3'b000, 3'b000, 0);
    tbl[7]  = mk(3'b100, 24'ha10000, 3'b000, 1, 0, 8'h00, 3'b000, 3'b000, 0);
    tbl[8]  = mk(3'b100, 24'ha10000, 3'b000, 1, 1, 8'ha1, 3'b100, 3'b100, 1);
    tbl[9]  = mk(3'b100, 24'ha20000, 3'b100, 0, 0, 8'ha2, 3'b000, 3'b100, 1);
    tbl[10] = mk(3'b100, 24'ha20000, 3'b100, 0, 0, 8'ha2, 3'b000, 3'b100, 1);
    tbl[11] = mk(3'b100, 24'ha20000, 3'b100, 1, 1, 8'ha2, 3'b100, 3'b100, 1);
    tbl[12] = mk(3'b000, 24'h000000, 3'b000, 1, 0, 8'h00, 3'b000, 3'b000, 1);
    tbl[13] = mk(3'b000, 24'h000000, 3'b000, 1, 0, 8'h00, 3'b000, 3'b000, 1);
    tbl[14] = mk(3'b010, 24'h00b100, 3'b000, 1, 0, 8'h00, 3'b000, 3'b000, 0);
    tbl[15] = mk(3'b011, 24'h00b1ff, 3'b001, 1, 1, 8'hb1, 3'b010, 3'b010, 1);
    tbl[16] = mk(3'b000, 24'h000000, 3'b000, 1, 0, 8'h00, 3'b000, 3'b010, 1);
    tbl[17] = mk(3'b100, 24'hc10000, 3'b100, 1, 0, 8'h00, 3'b000, 3'b000, 1);
    tbl[18] = mk(3'b100, 24'hc10000, 3'b100, 1, 0, 8'h00, 3'b000, 3'b000, 1);
    tbl[19] = mk(3'b100, 24'hc10000, 3'b100, 1, 0, 8'h00, 3'b000, 3'b000, 0);
    tbl[20] = mk(3'b100, 24'hc10000, 3'b100, 1, 1, 8'hc1, 3'b100, 3'b100, 1);
    tbl[21] = mk(3'b000, 24'h000000, 3'b000, 1, 0, 8'h00, 3'b000, 3'b000, 1);
    tbl[22] = mk(3'b000, 24'h000000, 3'b000, 1, 0, 8'h00, 3'b000, 3'b000, 1);
    tbl[23] = mk(3'b000, 24'h000000, 3'b000, 1, 0, 8'h00, 3'b000, 3'b000, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_out("reset", 0, 8'h00, 3'b000, 3'b000, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      req = tbl[i].req; req_data = tbl[i].data; req_last = tbl[i].last; tx_rdy = tbl[i].rdy;
      @(negedge clk);
      chk_out($sformatf("vec%0d", i), tbl[i].en, tbl[i].txd, tbl[i].ack, tbl[i].gnt, tbl[i].bsy);
      @(posedge clk); #1;
    end

    // two requesters, two 2-byte packets each
`ifdef UART_TX_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 1, 1};
`else
    exp_order = '{0, 1, 0, 1};
`endif
    rst = 1'b1; #2; rst = 1'b0;
    bi = '{0, 0};
    cur = -1;
    tx_rdy = 1'b1;
    for (int cyc = 0; cyc < 100 && (bi[0] < 4 || bi[1] < 4); cyc++) begin
      req = {1'b0, bi[1] < 4, bi[0] < 4};
      req_data = {8'h00, 4'h1, 4'(bi[1]), 4'h0, 4'(bi[0])};
      req_last = {1'b0, bi[1] % 2 == 1, bi[0] % 2 == 1};
      @(negedge clk);
      if (req_ack != 3'b000) begin
        who = req_ack[1] ? 1 : 0;
        check("t2_ack_onehot", 32'(req_ack), 32'(1 << who));
        check("t2_data", 32'(tx_data), 32'({4'(who), 4'(bi[who])}));
        if (bi[who] % 2 == 0) begin
          order.push_back(who);
          cur = who;
        end else begin
          check("t2_no_interleave", 32'(who), 32'(cur));
        end
        bi[who]++;
      end
      @(posedge clk); #1;
    end
    check("t2_bytes_done", 32'(bi[0] + bi[1]), 32'd8);
    check("t2_npkts", 32'(order.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < order.size()) check($sformatf("t2_order%0d", k), 32'(order[k]), 32'(exp_order[k]));
    end
    req = '0; req_last = '0;
    repeat (4) @(posedge clk);
    #1;

    // reset mid-packet, then rr_ptr back to 0
    req = 3'b001; req_data = 24'h000055; req_last = 3'b000; tx_rdy = 1'b1;
    @(negedge clk);
    chk_out("t5_idle", 0, 8'h00, 3'b000, 3'b000, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk_out("t5_send", 1, 8'h55, 3'b001, 3'b001, 1);
    #1 rst = 1'b1;
    #1 chk_out("t5_rst", 0, 8'h00, 3'b000, 3'b000, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    req = 3'b101; req_data = 24'h770066; req_last = 3'b101;
    @(negedge clk);
    chk_out("t5_idle2", 0, 8'h00, 3'b000, 3'b000, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk_out("t5_rr0", 1, 8'h66, 3'b001, 3'b001, 1);

    // requests arriving during GAP wait for IDLE
    @(posedge clk); #1;
    req = 3'b011; req_data = 24'h008866; req_last = 3'b011;
    @(negedge clk);
    chk_out("t6_gap1", 0, 8'h00, 3'b000, 3'b000, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk_out("t6_gap2", 0, 8'h00, 3'b000, 3'b000, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk_out("t6_idle", 0, 8'h00, 3'b000, 3'b000, 0);
    @(posedge clk); #1;
    @(negedge clk);
`ifdef UART_TX_ARB_FIXED_PRIO_EN
    chk_out("t6_win", 1, 8'h66, 3'b001, 3'b001, 1);
`else
    chk_out("t6_win", 1, 8'h88, 3'b010, 3'b010, 1);
`endif
    @(posedge clk); #1;
    req = '0; req_last = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
